// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fsm
//  Brief    : UART receive sequencer; gates the oversampling counter, sampler,
//             deserializer and parity checker, and flags each received frame.
//  Revision : 1.0
// ============================================================================
module uart_rx_fsm #(
    parameter int EDGE_MAX = 8,
    parameter int CHK_EDGE = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       sampled_bit,
    input  logic       par_err,
    input  logic [3:0] bit_cnt,
    input  logic [3:0] edge_cnt,
    output logic       edge_bit_en,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       data_valid,
    output logic       par_error,
    output logic       frame_error,
    output logic       busy
);

    localparam logic [3:0] c_edge_last = 4'(EDGE_MAX);
    localparam logic [3:0] c_chk_edge  = 4'(CHK_EDGE);
    localparam logic [3:0] c_last_data = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state_q;
    logic   par_en_q;
    logic   par_err_q;
    logic   stp_err_q;

    logic   w_at_chk;
    logic   w_at_last;

    assign w_at_chk  = (edge_cnt == c_chk_edge);
    assign w_at_last = (edge_cnt == c_edge_last);

    assign busy        = (state_q != S_IDLE);
    assign edge_bit_en = busy;
    assign dat_samp_en = busy;
    assign deser_en    = (state_q == S_DATA)   && w_at_chk;
    assign par_chk_en  = (state_q == S_PARITY) && w_at_chk;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            par_en_q    <= 1'b0;
            par_err_q   <= 1'b0;
            stp_err_q   <= 1'b0;
            data_valid  <= 1'b0;
            par_error   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!RX_IN) begin
                        state_q   <= S_START;
                        par_en_q  <= PAR_EN;
                        par_err_q <= 1'b0;
                        stp_err_q <= 1'b0;
                    end
                end
                S_START: begin
                    // A high majority at the check point means the low was a glitch.
                    if (w_at_chk && sampled_bit) begin
                        state_q <= S_IDLE;
                    end else if (w_at_last) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_at_last && (bit_cnt == c_last_data)) begin
                        state_q <= par_en_q ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (w_at_last) begin
                        par_err_q <= par_err;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_at_chk) begin
                        stp_err_q <= ~sampled_bit;
                    end
                    if (w_at_last) begin
                        state_q     <= S_IDLE;
                        data_valid  <= ~(par_err_q | stp_err_q);
                        par_error   <= par_err_q;
                        frame_error <= stp_err_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fsm
//  Brief    : Self-checking bench for uart_rx_fsm with a behavioural counter
//             and line/sampler model driving the feedback inputs.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx_fsm;

    localparam int EDGE_MAX = 8;
    localparam int CHK_EDGE = 7;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       sampled_bit;
    logic       par_err;
    logic [3:0] bit_cnt;
    logic [3:0] edge_cnt;
    logic       edge_bit_en, dat_samp_en, deser_en, par_chk_en;
    logic       data_valid, par_error, frame_error, busy;

    logic [7:0] cfg_data  = 8'h00;
    logic       cfg_par   = 1'b0;
    logic       cfg_perr  = 1'b0;
    logic       cfg_stop  = 1'b1;
    logic       cfg_start = 1'b0;
    logic       line_v;
    logic [3:0] idx;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fsm #(.EDGE_MAX(EDGE_MAX), .CHK_EDGE(CHK_EDGE)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .sampled_bit(sampled_bit), .par_err(par_err),
        .bit_cnt(bit_cnt), .edge_cnt(edge_cnt),
        .edge_bit_en(edge_bit_en), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .par_chk_en(par_chk_en),
        .data_valid(data_valid), .par_error(par_error),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Edge/bit counter as the RX datapath would implement it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= 4'd1;
            bit_cnt  <= 4'd1;
        end else if (!edge_bit_en) begin
            edge_cnt <= 4'd1;
            bit_cnt  <= 4'd1;
        end else if (edge_cnt == 4'(EDGE_MAX)) begin
            edge_cnt <= 4'd1;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 4'd1;
        end
    end

    // Sampler and parity checker: correct only where they are defined valid.
    always_comb begin
        line_v = 1'b1;
        idx    = bit_cnt - 4'd2;
        if (bit_cnt == 4'd1)
            line_v = cfg_start;
        else if (bit_cnt >= 4'd2 && bit_cnt <= 4'd9)
            line_v = cfg_data[idx[2:0]];
        else if (bit_cnt == 4'd10)
            line_v = cfg_par ? ^cfg_data : cfg_stop;
        else if (bit_cnt == 4'd11)
            line_v = cfg_stop;
        sampled_bit = (edge_cnt >= 4'(CHK_EDGE)) ? line_v : ~line_v;
        par_err = (bit_cnt == 4'd10 && edge_cnt == 4'(EDGE_MAX)) ? cfg_perr : ~cfg_perr;
    end

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       perr;
        logic       stop;
        logic       start;
        int         fall_k;
        int         dv_k;
        int         pchk_k;
        int         ndeser;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int fall, dv_k, ndv, nd, first_d, last_d, pchk_k, npchk;
        fall = -1; dv_k = -1; ndv = 0; nd = 0;
        first_d = -1; last_d = -1; pchk_k = -1; npchk = 0;
        @(negedge CLK);
        cfg_data = v.data; cfg_par = v.par_en; cfg_perr = v.perr;
        cfg_stop = v.stop; cfg_start = v.start;
        PAR_EN = v.par_en;
        RX_IN  = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, ".busy_at_start"}, 32'(busy), 1);
        PAR_EN = ~v.par_en;
        for (int k = 0; k < 120; k++) begin
            @(negedge CLK);
            if (k == 2) RX_IN = 1'b1;
            if (deser_en) begin
                nd++;
                if (first_d < 0) first_d = k;
                last_d = k;
            end
            if (par_chk_en) begin
                npchk++;
                pchk_k = k;
            end
            if (data_valid) begin
                ndv++;
                dv_k = k;
            end
            if (!busy && fall < 0) fall = k;
            if (fall >= 0 && k >= fall + 3) break;
        end
        PAR_EN = 1'b0;
        check({tag, ".busy_fall"},   fall,   v.fall_k);
        check({tag, ".dv_cycle"},    dv_k,   v.dv_k);
        check({tag, ".dv_count"},    ndv,    (v.dv_k >= 0) ? 1 : 0);
        check({tag, ".deser_count"}, nd,     v.ndeser);
        check({tag, ".deser_first"}, first_d, (v.ndeser > 0) ? 14 : -1);
        check({tag, ".deser_last"},  last_d,  (v.ndeser > 0) ? 70 : -1);
        check({tag, ".pchk_cycle"},  pchk_k, v.pchk_k);
        check({tag, ".pchk_count"},  npchk,  (v.pchk_k >= 0) ? 1 : 0);
        check({tag, ".par_error"},   32'(par_error),   32'(v.exp_pe));
        check({tag, ".frame_error"}, 32'(frame_error), 32'(v.exp_fe));
    endtask

    initial begin
        int k, dv1, dv2, ndv;
        logic rearm;

        //          data   par   perr  stop  start fall dv   pchk nd  pe    fe
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 80, 80, -1, 8, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 88, 88, 78, 8, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 88, -1, 78, 8, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1,  7, -1, -1, 0, 1'b1, 1'b0};
        vecs[4] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 80, -1, -1, 8, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 80, 80, -1, 8, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 88, -1, 78, 8, 1'b1, 1'b1};

        #1;
        check("rst.busy",        32'(busy),        0);
        check("rst.edge_bit_en", 32'(edge_bit_en), 0);
        check("rst.dat_samp_en", 32'(dat_samp_en), 0);
        check("rst.deser_en",    32'(deser_en),    0);
        check("rst.par_chk_en",  32'(par_chk_en),  0);
        check("rst.data_valid",  32'(data_valid),  0);
        check("rst.par_error",   32'(par_error),   0);
        check("rst.frame_error", 32'(frame_error), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle.busy", 32'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of data bit 5 after an errored frame.
        @(negedge CLK);
        cfg_data = 8'h5A; cfg_par = 1'b0; cfg_perr = 1'b0;
        cfg_stop = 1'b1; cfg_start = 1'b0;
        RX_IN = 1'b0;
        @(negedge CLK);
        RX_IN = 1'b1;
        k = 0;
        while (!(bit_cnt == 4'd5 && edge_cnt == 4'd3) && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("mid.reached_bit5", 32'(k < 100), 1);
        check("mid.busy_before",  32'(busy), 1);
        RST = 1'b0;
        #1;
        check("mid.busy",        32'(busy),        0);
        check("mid.edge_bit_en", 32'(edge_bit_en), 0);
        check("mid.dat_samp_en", 32'(dat_samp_en), 0);
        check("mid.deser_en",    32'(deser_en),    0);
        check("mid.par_chk_en",  32'(par_chk_en),  0);
        check("mid.data_valid",  32'(data_valid),  0);
        check("mid.par_error",   32'(par_error),   0);
        check("mid.frame_error", 32'(frame_error), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        ndv = 0;
        for (int j = 0; j < 90; j++) begin
            @(negedge CLK);
            if (data_valid) ndv++;
        end
        check("mid.no_dv_after", ndv, 0);
        run_frame(vecs[5], "post_rst");

        // Back-to-back: second start driven in the first IDLE cycle.
        dv1 = -1; dv2 = -1; ndv = 0; rearm = 1'b0;
        @(negedge CLK);
        cfg_data = 8'hA5; cfg_par = 1'b0; cfg_stop = 1'b1; cfg_start = 1'b0;
        RX_IN = 1'b0;
        @(posedge CLK);
        for (int j = 0; j < 200; j++) begin
            @(negedge CLK);
            if (j == 2) RX_IN = 1'b1;
            if (rearm) begin
                check("b2b.busy_restart", 32'(busy), 1);
                RX_IN = 1'b1;
                rearm = 1'b0;
            end
            if (data_valid) begin
                ndv++;
                if (dv1 < 0) begin
                    dv1 = j;
                    RX_IN = 1'b0;
                    rearm = 1'b1;
                end else begin
                    dv2 = j;
                end
            end
            if (dv2 >= 0 && j >= dv2 + 3) break;
        end
        check("b2b.dv1_cycle", dv1, 80);
        check("b2b.dv_gap",    (dv2 >= 0) ? dv2 - dv1 : -1, 81);
        check("b2b.dv_count",  ndv, 2);
        check("b2b.frame_error", 32'(frame_error), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
